// File: rtl/jtag_driver_pkg.sv
// Shared types and scan-length constants for the JTAG initiator.
// Readback capture is enabled by defining JTAG_DRIVER_RDBACK_EN.
package jtag_driver_pkg;

    typedef enum logic [1:0] {
        OP_RESET    = 2'd0,
        OP_SHIFT_DR = 2'd1,
        OP_SHIFT_IR = 2'd2,
        OP_RUNIDLE  = 2'd3
    } jtag_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } jtag_state_e;

    localparam logic [5:0] DR_PRE    = 6'd3;
    localparam logic [5:0] DR_POST   = 6'd2;
    localparam logic [5:0] IR_PRE    = 6'd4;
    localparam logic [5:0] IR_POST   = 6'd2;
    localparam logic [5:0] RESET_LEN = 6'd6;

    function automatic logic is_scan(jtag_op_e op);
        return (op == OP_SHIFT_DR) || (op == OP_SHIFT_IR);
    endfunction

    function automatic logic [5:0] preamble_len(jtag_op_e op);
        case (op)
            OP_SHIFT_DR: return DR_PRE;
            OP_SHIFT_IR: return IR_PRE;
            default:     return 6'd0;
        endcase
    endfunction

    // Total TCKs for a command; len is the bit/idle count minus one.
    function automatic logic [5:0] tck_count(jtag_op_e op, logic [4:0] len);
        logic [5:0] nb;
        nb = {1'b0, len} + 6'd1;
        case (op)
            OP_RESET:    return RESET_LEN;
            OP_SHIFT_DR: return DR_PRE + nb + DR_POST;
            OP_SHIFT_IR: return IR_PRE + nb + IR_POST;
            default:     return nb;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// TCK divider: CLK_DIV cycles low then CLK_DIV high; fall/rise strobes flag
// the coming i_clk edge on which TCK changes. Stopped means TCK held low.
module jtag_tck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic run,
    output logic tck,
    output logic fall,
    output logic rise
);
    localparam int PW = $clog2(2 * CLK_DIV);

    logic [PW-1:0] pos;

    assign fall = run && (pos == '0);
    assign rise = run && (pos == PW'(CLK_DIV));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pos <= '0;
            tck <= 1'b0;
        end else if (!run) begin
            pos <= '0;
            tck <= 1'b0;
        end else begin
            pos <= (pos == PW'(2 * CLK_DIV - 1)) ? '0 : pos + PW'(1);
            if (fall)
                tck <= 1'b0;
            else if (rise)
                tck <= 1'b1;
        end
    end

endmodule

// File: rtl/jtag_driver.sv
// Host-side JTAG initiator: walks the TAP through reset, IR/DR scans and idle.
// TDO capture into o_rspData exists only when JTAG_DRIVER_RDBACK_EN is defined.
module jtag_driver
    import jtag_driver_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cmdValid,
    output logic        o_cmdReady,
    input  logic [1:0]  i_cmdOp,
    input  logic [4:0]  i_cmdLen,
    input  logic [31:0] i_cmdData,
    output logic        o_done,
    output logic [31:0] o_rspData,
    output logic        o_jtagTCK,
    output logic        o_jtagTMS,
    output logic        o_jtagTDI,
    input  logic        i_jtagTDO
);
    jtag_state_e state, state_nxt;
    jtag_op_e    op_q;
    logic [4:0]  len_q;
    logic [31:0] data_sr;
    logic [5:0]  idx;
    logic        tms_q, tdi_q;
    logic        run, accept, tck_fall, tck_rise;
    logic [5:0]  n_tck, pre, nbits;
    logic [4:0]  cap_k;
    logic        shift_now, shift_cap, tms_nxt, last_tck;

    assign accept    = (state == ST_IDLE) && i_cmdValid;
    assign run       = (state == ST_RUN);
    assign o_jtagTMS = tms_q;
    assign o_jtagTDI = tdi_q;

    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .run   (run),
        .tck   (o_jtagTCK),
        .fall  (tck_fall),
        .rise  (tck_rise)
    );

    // idx counts TCKs already started: at a fall it names the TCK about to
    // begin, during a high phase it is one past the TCK being sampled.
    always_comb begin
        nbits     = {1'b0, len_q} + 6'd1;
        pre       = preamble_len(op_q);
        n_tck     = tck_count(op_q, len_q);
        last_tck  = (idx == n_tck);
        shift_now = is_scan(op_q) && (idx >= pre) && (idx < pre + nbits);
        shift_cap = is_scan(op_q) && (idx > pre) && (idx <= pre + nbits);
        cap_k     = 5'(idx - pre - 6'd1);
        tms_nxt   = 1'b0;
        case (op_q)
            OP_RESET:   tms_nxt = (idx < 6'd5);
            OP_RUNIDLE: tms_nxt = 1'b0;
            default: begin
                if (idx < pre)
                    tms_nxt = (op_q == OP_SHIFT_IR) ? (idx < 6'd2) : (idx == 6'd0);
                else
                    tms_nxt = (idx == pre + nbits - 6'd1) || (idx == pre + nbits);
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        o_cmdReady = 1'b0;
        o_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                o_cmdReady = 1'b1;
                if (i_cmdValid)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (tck_fall && last_tck)
                    state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_done    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The final TCK of every op has TMS=0/TDI=0, so the closing fall edge
    // leaves the pins alone.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            op_q    <= OP_RESET;
            len_q   <= '0;
            data_sr <= '0;
            idx     <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else if (accept) begin
            op_q    <= jtag_op_e'(i_cmdOp);
            len_q   <= i_cmdLen;
            data_sr <= i_cmdData;
            idx     <= '0;
        end else if (run && tck_fall && !last_tck) begin
            tms_q <= tms_nxt;
            tdi_q <= shift_now & data_sr[0];
            if (shift_now)
                data_sr <= data_sr >> 1;
            idx <= idx + 6'd1;
        end
    end

`ifdef JTAG_DRIVER_RDBACK_EN
    logic [31:0] rsp_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            rsp_q <= '0;
        else if (accept)
            rsp_q <= '0;
        else if (run && tck_rise && shift_cap)
            rsp_q[cap_k] <= i_jtagTDO;
    end

    assign o_rspData = rsp_q;
`else
    logic unused_rdback;
    assign unused_rdback = ^{i_jtagTDO, tck_rise, shift_cap, cap_k};
    assign o_rspData     = '0;
`endif

endmodule

// File: tb/tb_jtag_driver.sv
// Self-checking bench for jtag_driver: spec-level sequence model, a TAP model
// and randomized commands.
module tb_jtag_driver;
    import jtag_driver_pkg::*;

    localparam int D = 2;
`ifdef JTAG_DRIVER_RDBACK_EN
    localparam bit RDB = 1'b1;
`else
    localparam bit RDB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [4:0]  len = 5'd0;
    logic [31:0] data = 32'd0;
    logic        ready, done, tck, tms, tdi, tdo;
    logic [31:0] rsp;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int rise_cnt = 0;
    int tdo_mode = 1;
    logic [63:0] tdo_word = 64'd0;
    logic mon_tms[$], mon_tdi[$], exp_tms[$], exp_tdi[$];

    always #5 clk = ~clk;

    jtag_driver #(.CLK_DIV(D)) dut (
        .i_clk(clk), .i_rst(rst), .i_cmdValid(valid), .o_cmdReady(ready),
        .i_cmdOp(op), .i_cmdLen(len), .i_cmdData(data), .o_done(done),
        .o_rspData(rsp), .o_jtagTCK(tck), .o_jtagTMS(tms), .o_jtagTDI(tdi),
        .i_jtagTDO(tdo)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cnt = done_cnt + 1;

    always @(posedge tck) begin
        mon_tms.push_back(tms);
        mon_tdi.push_back(tdi);
        rise_cnt <= rise_cnt + 1;
    end

    // Reference TAP: standard 16-state controller with a 32-bit IR.
    typedef enum int {T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR,
                      T_UPDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR} tap_e;
    tap_e        tap_st = T_TLR;
    logic [31:0] ir_sr = 32'd0;
    logic [31:0] tap_ir = 32'd0;

    function automatic tap_e tap_next(tap_e s, logic m);
        case (s)
            T_TLR:   return m ? T_TLR   : T_RTI;
            T_RTI:   return m ? T_SELDR : T_RTI;
            T_SELDR: return m ? T_SELIR : T_CAPDR;
            T_CAPDR: return m ? T_EX1DR : T_SHDR;
            T_SHDR:  return m ? T_EX1DR : T_SHDR;
            T_EX1DR: return m ? T_UPDR  : T_PADR;
            T_PADR:  return m ? T_EX2DR : T_PADR;
            T_EX2DR: return m ? T_UPDR  : T_SHDR;
            T_UPDR:  return m ? T_SELDR : T_RTI;
            T_SELIR: return m ? T_TLR   : T_CAPIR;
            T_CAPIR: return m ? T_EX1IR : T_SHIR;
            T_SHIR:  return m ? T_EX1IR : T_SHIR;
            T_EX1IR: return m ? T_UPIR  : T_PAIR;
            T_PAIR:  return m ? T_EX2IR : T_PAIR;
            T_EX2IR: return m ? T_UPIR  : T_SHIR;
            T_UPIR:  return m ? T_SELDR : T_RTI;
            default: return T_TLR;
        endcase
    endfunction

    always @(posedge tck) begin
        if (tap_st == T_CAPIR) ir_sr <= 32'h1;
        else if (tap_st == T_SHIR) ir_sr <= {tdi, ir_sr[31:1]};
        if (tap_st == T_UPIR) tap_ir <= ir_sr;
        tap_st <= tap_next(tap_st, tms);
    end

    assign tdo = (tdo_mode == 0) ? tdo_word[rise_cnt[5:0]] :
                 (tdo_mode == 1) ? tdi : ((tap_st == T_SHIR) ? ir_sr[0] : 1'b0);

    // Expected TMS/TDI per TCK straight from the op definitions.
    function automatic void build_exp(logic [1:0] o, logic [4:0] l, logic [31:0] d);
        int nb;
        nb = int'(l) + 1;
        exp_tms.delete();
        exp_tdi.delete();
        if (o == 2'd0) begin
            for (int i = 0; i < 6; i++) begin exp_tms.push_back(i < 5); exp_tdi.push_back(1'b0); end
        end else if (o == 2'd3) begin
            for (int i = 0; i < nb; i++) begin exp_tms.push_back(1'b0); exp_tdi.push_back(1'b0); end
        end else begin
            exp_tms.push_back(1'b1);
            if (o == 2'd2) exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
            exp_tms.push_back(1'b0);
            for (int i = 0; i < exp_tms.size(); i++) exp_tdi.push_back(1'b0);
            for (int k = 0; k < nb; k++) begin exp_tms.push_back(k == nb - 1); exp_tdi.push_back(d[k]); end
            exp_tms.push_back(1'b1); exp_tdi.push_back(1'b0);
            exp_tms.push_back(1'b0); exp_tdi.push_back(1'b0);
        end
    endfunction

    // First differing TCK index between observed and expected pins, -1 if equal.
    function automatic int seq_diff();
        if (mon_tms.size() != exp_tms.size()) return 999;
        for (int i = 0; i < exp_tms.size(); i++)
            if (mon_tms[i] !== exp_tms[i] || mon_tdi[i] !== exp_tdi[i]) return i;
        return -1;
    endfunction

    task automatic run_cmd(input logic [1:0] o, input logic [4:0] l, input logic [31:0] d,
                           output int lat);
        int g, acc;
        @(negedge clk);
        op = o; len = l; data = d; valid = 1'b1;
        mon_tms.delete(); mon_tdi.delete(); rise_cnt = 0;
        g = 0;
        while (!ready && g < 500) begin @(negedge clk); g++; end
        acc = cyc + 1;
        @(negedge clk);
        valid = 1'b0;
        g = 0;
        while (!done && g < 2000) begin @(negedge clk); g++; end
        lat = done ? (cyc - acc) : -1;
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        tests++; if (tck !== 1'b0) begin fails++; $display("FAIL reset_tck got %b exp 0", tck); end
        tests++; if (tms !== 1'b1) begin fails++; $display("FAIL reset_tms got %b exp 1", tms); end
        tests++; if (tdi !== 1'b0) begin fails++; $display("FAIL reset_tdi got %b exp 0", tdi); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b exp 1", ready); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        tests++; if (rsp !== 32'd0) begin fails++; $display("FAIL reset_rsp got %h exp 0", rsp); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_op_reset();
        int lat, dff;
        build_exp(2'd0, 5'd0, 32'd0);
        run_cmd(2'd0, 5'd0, 32'd0, lat);
        dff = seq_diff();
        tests++; if (lat != 25) begin fails++; $display("FAIL opreset_latency got %0d exp 25", lat); end
        tests++; if (dff != -1) begin fails++; $display("FAIL opreset_seq first diff at %0d exp -1", dff); end
    endtask

    task automatic test_dr_loopback();
        int lat, dff;
        tdo_mode = 1;
        build_exp(2'd1, 5'd7, 32'hA5);
        run_cmd(2'd1, 5'd7, 32'hA5, lat);
        dff = seq_diff();
        tests++; if (lat != 53) begin fails++; $display("FAIL dr_latency got %0d exp 53", lat); end
        tests++; if (dff != -1) begin fails++; $display("FAIL dr_seq first diff at %0d exp -1", dff); end
        tests++; if (rsp !== (RDB ? 32'hA5 : 32'h0)) begin
            fails++; $display("FAIL dr_rsp got %h exp %h", rsp, RDB ? 32'hA5 : 32'h0); end
    endtask

    task automatic test_ir_tap();
        int lat, dff;
        tdo_mode = 2;
        run_cmd(2'd0, 5'd0, 32'd0, lat);
        build_exp(2'd2, 5'd31, 32'hDEADBEEF);
        run_cmd(2'd2, 5'd31, 32'hDEADBEEF, lat);
        dff = seq_diff();
        tests++; if (lat != 38 * 2 * D + 1) begin fails++; $display("FAIL ir_latency got %0d exp %0d", lat, 38 * 2 * D + 1); end
        tests++; if (dff != -1) begin fails++; $display("FAIL ir_seq first diff at %0d exp -1", dff); end
        tests++; if (tap_ir !== 32'hDEADBEEF) begin fails++; $display("FAIL ir_tap_ir got %h exp deadbeef", tap_ir); end
        tests++; if (tap_st != T_RTI) begin fails++; $display("FAIL ir_tap_state got %0d exp %0d", tap_st, T_RTI); end
        tests++; if (rsp !== (RDB ? 32'h1 : 32'h0)) begin
            fails++; $display("FAIL ir_rsp got %h exp %h", rsp, RDB ? 32'h1 : 32'h0); end
    endtask

    task automatic test_random();
        int lat, dff, pre;
        logic [1:0]  o;
        logic [4:0]  l;
        logic [31:0] d, er;
        tdo_mode = 0;
        for (int n = 0; n < 20; n++) begin
            o = 2'($urandom_range(0, 3));
            l = 5'($urandom_range(0, 31));
            d = $urandom;
            tdo_word = {$urandom, $urandom};
            build_exp(o, l, d);
            run_cmd(o, l, d, lat);
            dff = seq_diff();
            pre = (o == 2'd1) ? 3 : 4;
            er = 32'd0;
            if (RDB && (o == 2'd1 || o == 2'd2))
                for (int k = 0; k <= int'(l); k++) er[k] = tdo_word[pre + k];
            tests++; if (lat != exp_tms.size() * 2 * D + 1) begin
                fails++; $display("FAIL rand_latency op %0d len %0d got %0d exp %0d", o, l, lat, exp_tms.size() * 2 * D + 1); end
            tests++; if (dff != -1) begin
                fails++; $display("FAIL rand_seq op %0d len %0d first diff at %0d exp -1", o, l, dff); end
            tests++; if (rsp !== er) begin
                fails++; $display("FAIL rand_rsp op %0d len %0d got %h exp %h", o, l, rsp, er); end
        end
    endtask

    task automatic test_back_to_back();
        int g, acc1, acc2, lat1, lat2;
        bit ready_bad;
        tdo_mode = 1;
        @(negedge clk);
        op = 2'd1; len = 5'd3; data = 32'h5; valid = 1'b1;
        mon_tms.delete(); mon_tdi.delete(); rise_cnt = 0;
        acc1 = cyc + 1;
        @(negedge clk);
        op = 2'd3; len = 5'd4; data = 32'h0;
        ready_bad = 1'b0; g = 0;
        while (!done && g < 500) begin
            if (ready) ready_bad = 1'b1;
            @(negedge clk); g++;
        end
        if (ready) ready_bad = 1'b1;
        lat1 = cyc - acc1;
        tests++; if (ready_bad) begin fails++; $display("FAIL b2b_ready_busy got high exp low"); end
        tests++; if (lat1 != 9 * 2 * D + 1) begin fails++; $display("FAIL b2b_lat1 got %0d exp %0d", lat1, 9 * 2 * D + 1); end
        tests++; if (tck !== 1'b0) begin fails++; $display("FAIL b2b_tck_done got %b exp 0", tck); end
        @(negedge clk);
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_after_done got %b exp 1", ready); end
        tests++; if (tck !== 1'b0) begin fails++; $display("FAIL b2b_tck_idle got %b exp 0", tck); end
        acc2 = cyc + 1;
        @(negedge clk);
        valid = 1'b0;
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL b2b_second_accept ready got %b exp 0", ready); end
        g = 0;
        while (!done && g < 500) begin @(negedge clk); g++; end
        lat2 = done ? cyc - acc2 : -1;
        tests++; if (lat2 != 5 * 2 * D + 1) begin fails++; $display("FAIL b2b_lat2 got %0d exp %0d", lat2, 5 * 2 * D + 1); end
        tests++; if (mon_tms.size() != 14) begin fails++; $display("FAIL b2b_tck_count got %0d exp 14", mon_tms.size()); end
    endtask

    task automatic test_abort();
        int g, d0;
        tdo_mode = 1;
        @(negedge clk);
        op = 2'd1; len = 5'd15; data = 32'hFFFF; valid = 1'b1;
        rise_cnt = 0;
        @(negedge clk);
        valid = 1'b0;
        g = 0;
        while (rise_cnt < 4 && g < 500) begin @(negedge clk); g++; end
        tests++; if (rise_cnt != 4 || tck !== 1'b1) begin
            fails++; $display("FAIL abort_reach_4th_high rises %0d tck %b exp 4/1", rise_cnt, tck); end
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        tests++; if (tck !== 1'b0) begin fails++; $display("FAIL abort_tck got %b exp 0", tck); end
        tests++; if (tms !== 1'b1) begin fails++; $display("FAIL abort_tms got %b exp 1", tms); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b exp 1", ready); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        tests++; if (done_cnt != d0) begin fails++; $display("FAIL abort_no_done got %0d pulses exp 0", done_cnt - d0); end
        tests++; if (rsp !== 32'd0) begin fails++; $display("FAIL abort_rsp got %h exp 0", rsp); end
        tests++; if (tck !== 1'b0) begin fails++; $display("FAIL abort_tck_idle got %b exp 0", tck); end
    endtask

    initial begin
        test_reset();
        test_op_reset();
        test_dr_loopback();
        test_ir_tap();
        test_random();
        test_back_to_back();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
